// File: rtl/fastram_pkg.sv
// Shared types for the Fast RAM sequencer: FSM states, bank limits and the registered output bundle.
// drive_cycle() builds the output bundle for one clock of an active SRAM cycle.
package fastram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam int         BANKS_4MB = 2;
    localparam int         BANKS_8MB = 4;
    localparam logic [2:0] CPU_SPACE = 3'b111;

    typedef struct packed {
        logic [3:0] ce_n;
        logic       oe_n;
        logic       we_n;
        logic       ub_n;
        logic       lb_n;
        logic       dtack_n;
        logic       dtack_oe;
        logic       ram_access;
    } ram_out_t;

    localparam ram_out_t OUT_IDLE = '{
        ce_n:       4'hF,
        oe_n:       1'b1,
        we_n:       1'b1,
        ub_n:       1'b1,
        lb_n:       1'b1,
        dtack_n:    1'b1,
        dtack_oe:   1'b0,
        ram_access: 1'b0
    };

    // WE only when a write has at least one byte lane strobed.
    function automatic ram_out_t drive_cycle(input logic [1:0] bank,
                                             input logic       rw_n,
                                             input logic       uds_n,
                                             input logic       lds_n);
        ram_out_t o;
        o            = OUT_IDLE;
        o.ce_n[bank] = 1'b0;
        o.oe_n       = ~rw_n;
        o.we_n       = rw_n | (uds_n & lds_n);
        o.ub_n       = uds_n;
        o.lb_n       = lds_n;
        o.dtack_oe   = 1'b1;
        o.ram_access = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/fastram_decode.sv
// Combinational address decode of a CPU cycle against the autoconfig base; 3-bit modulo offset so the window wraps.
// Zero latency, no backpressure: the controller only samples hit/bank while idle.
module fastram_decode
    import fastram_pkg::*;
(
    input  logic       as_n,
    input  logic [2:0] fc,
    input  logic [2:0] a_high,
    input  logic [2:0] base_ram,
    input  logic       configured_n,
    input  logic       jp6,
    output logic       hit,
    output logic [1:0] bank
);

    logic [2:0] off;
    logic [3:0] limit;

    always_comb begin
        off   = a_high - base_ram;
        limit = jp6 ? 4'(BANKS_8MB) : 4'(BANKS_4MB);
        hit   = ~as_n & ~configured_n & (fc != CPU_SPACE) & ({1'b0, off} < limit);
        bank  = off[1:0];
    end

endmodule

// File: rtl/fastram_ctrl.sv
// Fast RAM cycle sequencer: chip select/strobes one clock after decode, DTACK WAIT_STATES clocks later.
// No backpressure; the CPU ends each cycle by raising AS, then RECOVERY idle clocks block the next decode.
module fastram_ctrl
    import fastram_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int RECOVERY    = 1,
    parameter int CNT_W       = 3
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS_CPU_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW_n,
    input  logic [2:0] FC,
    input  logic [2:0] A_HIGH,
    input  logic [2:0] BASE_RAM,
    input  logic       RAM_CONFIGURED_n,
    input  logic       JP6,
    output logic [3:0] RAM_CE_n,
    output logic       RAM_OE_n,
    output logic       RAM_WE_n,
    output logic       RAM_UB_n,
    output logic       RAM_LB_n,
    output logic       DTACK_n,
    output logic       DTACK_OE,
    output logic       RAM_ACCESS
);

    localparam logic [CNT_W-1:0] WS_CNT  = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] REC_CNT = CNT_W'(RECOVERY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bank_q, bank_d;
    logic             rw_q, rw_d;
    ram_out_t         out_q, out_d;

    logic             dec_hit;
    logic [1:0]       dec_bank;

    fastram_decode u_decode (
        .as_n         (AS_CPU_n),
        .fc           (FC),
        .a_high       (A_HIGH),
        .base_ram     (BASE_RAM),
        .configured_n (RAM_CONFIGURED_n),
        .jp6          (JP6),
        .hit          (dec_hit),
        .bank         (dec_bank)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rw_d    = rw_q;
        out_d   = OUT_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (dec_hit) begin
                    bank_d = dec_bank;
                    rw_d   = RW_n;
                    out_d  = drive_cycle(dec_bank, RW_n, UDS_n, LDS_n);
                    if (WS_CNT == '0) begin
                        state_d       = ST_ACK;
                        cnt_d         = '0;
                        out_d.dtack_n = 1'b0;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = WS_CNT;
                    end
                end
            end
            ST_ACCESS, ST_ACK: begin
                // AS going high ends the cycle whether or not DTACK was reached (abort/retry).
                if (AS_CPU_n) begin
                    if (REC_CNT == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RECOVER;
                        cnt_d   = REC_CNT;
                    end
                end else begin
                    out_d = drive_cycle(bank_q, rw_q, UDS_n, LDS_n);
                    if (state_q == ST_ACK || cnt_q <= ONE) begin
                        state_d       = ST_ACK;
                        cnt_d         = '0;
                        out_d.dtack_n = 1'b0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            ST_RECOVER: begin
                if (cnt_q <= ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            rw_q    <= 1'b1;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            rw_q    <= rw_d;
            out_q   <= out_d;
        end
    end

    assign RAM_CE_n   = out_q.ce_n;
    assign RAM_OE_n   = out_q.oe_n;
    assign RAM_WE_n   = out_q.we_n;
    assign RAM_UB_n   = out_q.ub_n;
    assign RAM_LB_n   = out_q.lb_n;
    assign DTACK_n    = out_q.dtack_n;
    assign DTACK_OE   = out_q.dtack_oe;
    assign RAM_ACCESS = out_q.ram_access;

endmodule

// File: tb/tb_fastram_ctrl.sv
// Drives two controllers (WAIT_STATES 1 and 3) from one bus; expected cycles are queued per instance
// and a negedge monitor assembles each observed SRAM cycle and compares it against the queue.
module tb_fastram_ctrl;

    localparam int NDUT = 2;
    localparam int WS0  = 1;
    localparam int WS1  = 3;
    localparam int REC  = 1;

    typedef struct {
        int         id;
        logic [3:0] ce_n;
        logic       oe_n;
        logic       we_n;
        logic       ub_n;
        logic       lb_n;
        int         dur;
        int         dtack;
        int         gap;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst, as_n, uds_n, lds_n, rw_n, cfg_n, jp6;
    logic [2:0] fc, a_high, base;

    logic [3:0] ce_n       [NDUT];
    logic       oe_n       [NDUT];
    logic       we_n       [NDUT];
    logic       ub_n       [NDUT];
    logic       lb_n       [NDUT];
    logic       dtack_n    [NDUT];
    logic       dtack_oe   [NDUT];
    logic       ram_access [NDUT];

    txn_t exp_q [NDUT][$];
    int   tests  = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fastram_ctrl #(
            .WAIT_STATES ((g == 0) ? WS0 : WS1),
            .RECOVERY    (REC),
            .CNT_W       (3)
        ) u_dut (
            .CLKCPU           (clk),
            .RESET            (rst),
            .AS_CPU_n         (as_n),
            .UDS_n            (uds_n),
            .LDS_n            (lds_n),
            .RW_n             (rw_n),
            .FC               (fc),
            .A_HIGH           (a_high),
            .BASE_RAM         (base),
            .RAM_CONFIGURED_n (cfg_n),
            .JP6              (jp6),
            .RAM_CE_n         (ce_n[g]),
            .RAM_OE_n         (oe_n[g]),
            .RAM_WE_n         (we_n[g]),
            .RAM_UB_n         (ub_n[g]),
            .RAM_LB_n         (lb_n[g]),
            .DTACK_n          (dtack_n[g]),
            .DTACK_OE         (dtack_oe[g]),
            .RAM_ACCESS       (ram_access[g])
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? WS0 : WS1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    txn_t  cur      [NDUT];
    int    idle_cnt [NDUT];
    bit    active   [NDUT];
    txn_t  e;
    string pfx;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < NDUT; g++) begin
                if (dtack_oe[g] === 1'b1) begin
                    if (!active[g]) begin
                        active[g]     = 1'b1;
                        cur[g].ce_n   = ce_n[g];
                        cur[g].oe_n   = oe_n[g];
                        cur[g].we_n   = we_n[g];
                        cur[g].ub_n   = ub_n[g];
                        cur[g].lb_n   = lb_n[g];
                        cur[g].dur    = 0;
                        cur[g].dtack  = 0;
                        cur[g].gap    = idle_cnt[g];
                    end
                    cur[g].dur = cur[g].dur + 1;
                    if (dtack_n[g] === 1'b0)
                        cur[g].dtack = cur[g].dtack + 1;
                    check($sformatf("dut%0d hold ce/access", g),
                          {27'd0, ce_n[g], ram_access[g]}, {27'd0, cur[g].ce_n, 1'b1});
                end else begin
                    if (active[g]) begin
                        active[g]   = 1'b0;
                        idle_cnt[g] = 0;
                        if (exp_q[g].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL dut%0d unexpected cycle: got ce_n %b, expected no cycle", g, cur[g].ce_n);
                        end else begin
                            e   = exp_q[g].pop_front();
                            pfx = $sformatf("dut%0d cycle%0d", g, e.id);
                            check({pfx, " ce_n"},  32'(cur[g].ce_n), 32'(e.ce_n));
                            check({pfx, " oe_n"},  32'(cur[g].oe_n), 32'(e.oe_n));
                            check({pfx, " we_n"},  32'(cur[g].we_n), 32'(e.we_n));
                            check({pfx, " ub_n"},  32'(cur[g].ub_n), 32'(e.ub_n));
                            check({pfx, " lb_n"},  32'(cur[g].lb_n), 32'(e.lb_n));
                            check({pfx, " active clocks"}, cur[g].dur, e.dur);
                            check({pfx, " dtack clocks"},  cur[g].dtack, e.dtack);
                            if (e.gap >= 0)
                                check({pfx, " idle gap"}, cur[g].gap, e.gap);
                        end
                    end
                    idle_cnt[g] = idle_cnt[g] + 1;
                    check($sformatf("dut%0d idle outputs", g),
                          {21'd0, ce_n[g], oe_n[g], we_n[g], ub_n[g], lb_n[g], dtack_n[g], dtack_oe[g], ram_access[g]},
                          {21'd0, 4'hF, 7'b1111100});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // n = clocks AS is held low from the decode edge; DTACK shows for n-WS of them.
    task automatic push_exp(input int id, input logic [3:0] ce, input logic rw, input logic u,
                            input logic l, input int n, input int gap);
        for (int g = 0; g < NDUT; g++) begin
            txn_t t;
            t.id    = id;
            t.ce_n  = ce;
            t.oe_n  = (rw == 1'b1) ? 1'b0 : 1'b1;
            t.we_n  = (rw == 1'b0 && !(u == 1'b1 && l == 1'b1)) ? 1'b0 : 1'b1;
            t.ub_n  = u;
            t.lb_n  = l;
            t.dur   = n;
            t.dtack = (n > ws_of(g)) ? n - ws_of(g) : 0;
            t.gap   = gap;
            exp_q[g].push_back(t);
        end
    endtask

    task automatic bus_cycle(input int id, input logic [2:0] a, input logic rw, input logic u,
                             input logic l, input int n, input int lead, input bit hit,
                             input logic [3:0] ce, input int gap, input bit scramble);
        logic [2:0] base_save;
        logic       cfg_save;
        if (hit)
            push_exp(id, ce, rw, u, l, n, gap);
        base_save = base;
        cfg_save  = cfg_n;
        a_high    = a;
        rw_n      = rw;
        uds_n     = u;
        lds_n     = l;
        as_n      = 1'b0;
        for (int i = 0; i < lead + n; i++) begin
            tick(1);
            if (scramble && i == lead) begin
                base  = base + 3'd3;
                cfg_n = 1'b1;
            end
        end
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        rw_n  = 1'b1;
        base  = base_save;
        cfg_n = cfg_save;
        tick(1);
    endtask

    initial begin
        rst    = 1'b1;
        as_n   = 1'b1;
        uds_n  = 1'b1;
        lds_n  = 1'b1;
        rw_n   = 1'b1;
        fc     = 3'b101;
        a_high = 3'd0;
        base   = 3'd1;
        cfg_n  = 1'b0;
        jp6    = 1'b1;
        tick(3);
        for (int g = 0; g < NDUT; g++)
            check($sformatf("dut%0d reset outputs", g),
                  {21'd0, ce_n[g], oe_n[g], we_n[g], ub_n[g], lb_n[g], dtack_n[g], dtack_oe[g], ram_access[g]},
                  {21'd0, 4'hF, 7'b1111100});
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // read, base 1, 8 MB, A_HIGH 3 -> bank 2
        bus_cycle(1, 3'd3, 1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 4'b1011, -1, 1'b0);
        tick(3);

        // low-byte write with base/config disturbed mid-cycle, then back-to-back read through recovery
        bus_cycle(2, 3'd2, 1'b0, 1'b1, 1'b0, 4, 0,   1'b1, 4'b1101, -1,      1'b1);
        bus_cycle(3, 3'd1, 1'b1, 1'b0, 1'b0, 4, REC, 1'b1, 4'b1110, REC + 1, 1'b0);
        tick(3);

        // wrap and size select
        base = 3'd7;
        jp6  = 1'b0;
        bus_cycle(4, 3'd7, 1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 4'b1110, -1, 1'b0);
        tick(3);
        bus_cycle(5, 3'd0, 1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 4'b1101, -1, 1'b0);
        tick(3);
        bus_cycle(6, 3'd1, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 4'hF,    -1, 1'b0);
        tick(3);
        jp6 = 1'b1;
        bus_cycle(7, 3'd2, 1'b1, 1'b0, 1'b0, 4, 0, 1'b1, 4'b0111, -1, 1'b0);
        tick(3);

        // no-hit cases
        cfg_n = 1'b1;
        bus_cycle(8, 3'd7, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 4'hF, -1, 1'b0);
        cfg_n = 1'b0;
        tick(3);
        fc = 3'b111;
        bus_cycle(9, 3'd0, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 4'hF, -1, 1'b0);
        fc = 3'b110;
        tick(3);
        a_high = 3'd1;
        as_n   = 1'b1;
        tick(4);

        // abort: AS released before the WAIT_STATES=3 instance reaches DTACK, then recovery
        bus_cycle(10, 3'd0, 1'b1, 1'b0, 1'b0, 2, 0,   1'b1, 4'b1101, -1,      1'b0);
        bus_cycle(11, 3'd1, 1'b0, 1'b0, 1'b1, 5, REC, 1'b1, 4'b1011, REC + 1, 1'b0);
        tick(3);

        // reset while both instances hold DTACK
        push_exp(12, 4'b0111, 1'b1, 1'b0, 1'b0, 4, -1);
        a_high = 3'd2;
        rw_n   = 1'b1;
        uds_n  = 1'b0;
        lds_n  = 1'b0;
        as_n   = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        tick(3);
        bus_cycle(13, 3'd1, 1'b1, 1'b0, 1'b0, 5, 0, 1'b1, 4'b1011, -1, 1'b0);
        tick(4);

        for (int g = 0; g < NDUT; g++)
            check($sformatf("dut%0d expected cycles outstanding", g), exp_q[g].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
